// File: rtl/border_msg_pkg.sv
// Shared constants and message packing helper for the border packer.
package border_msg_pkg;

  // Tag field layout inside a 64-bit GT message.
  localparam int unsigned TagMsb     = 55;
  localparam int unsigned TagLsb     = 48;
  // Top tag bit is the direction flag, owned by the message handler.
  localparam int unsigned DirBit     = TagMsb;
  localparam int unsigned StatsWidth = 16;

  // Place a zero-extended payload and channel index into a message; the
  // index lands in [tag_msb-1:tag_lsb], every other bit outside the payload
  // stays 0.
  function automatic logic [63:0] pack_msg(input logic [63:0] payload,
                                            input logic [63:0] idx,
                                            input int unsigned tag_lsb,
                                            input int unsigned tag_msb);
    logic [63:0] mask;
    mask = ((64'd1 << tag_msb) - 64'd1) & ~((64'd1 << tag_lsb) - 64'd1);
    return payload | ((idx << tag_lsb) & mask);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter.sv
// Combinational round-robin grant: first requester at or above rr_ptr,
// wrapping modulo NUM_CHANNELS.
module rr_grant_arbiter #(
  parameter int unsigned NUM_CHANNELS = 5,
  parameter int unsigned PTR_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [PTR_W-1:0]        rr_ptr,
  output logic                    grant_valid,
  output logic [PTR_W-1:0]        grant_idx
);

  // Walk offsets from the far end so the nearest requester is assigned last.
  always_comb begin
    int unsigned c;
    grant_valid = 1'b0;
    grant_idx   = '0;
    c           = 0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      c = (int'(rr_ptr) + i) % NUM_CHANNELS;
      if (req[c]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/border_rr_packer.sv
// Round-robin packer of border FIFO channels into 64-bit GT messages with a
// 2-entry registered skid buffer. Optional statistics counters are built
// when BORDER_PACKER_STATS_EN is defined.
module border_rr_packer
  import border_msg_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS      = 5,
  parameter int unsigned CHANNEL_WIDTH_IN  = 32,
  parameter int unsigned CHANNEL_WIDTH_OUT = 64,
  parameter int unsigned TAG_MSB           = TagMsb,
  parameter int unsigned TAG_LSB           = TagLsb
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH_IN-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0]                in_valid,
  output logic [NUM_CHANNELS-1:0]                in_ready,
  output logic [CHANNEL_WIDTH_OUT-1:0]           out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic [16*(NUM_CHANNELS+1)-1:0]         stats
);

  localparam int unsigned PtrW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  if (NUM_CHANNELS > (1 << (TAG_MSB - TAG_LSB)) || TAG_MSB >= CHANNEL_WIDTH_OUT) begin : g_bad_cfg
    $error("border_rr_packer: tag field cannot hold NUM_CHANNELS or exceeds message width");
  end

  logic [PtrW-1:0]              rr_ptr_q, rr_ptr_d, grant_idx;
  logic                         grant_valid, accept, pop;
  logic [1:0]                   count_q, count_d;
  logic                         wr_ptr_q, rd_ptr_q;
  logic [CHANNEL_WIDTH_OUT-1:0] skid_q [2];
  logic [CHANNEL_WIDTH_OUT-1:0] msg;

  rr_grant_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .PTR_W       (PtrW)
  ) u_arb (
    .req        (in_valid),
    .rr_ptr     (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  // Accept depends only on registered occupancy, never on out_ready.
  assign accept    = grant_valid & (count_q != 2'd2) & ~reset;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = skid_q[rd_ptr_q];
  assign busy      = (|in_valid) | out_valid;
  assign msg       = CHANNEL_WIDTH_OUT'(pack_msg(64'(in_data[grant_idx*CHANNEL_WIDTH_IN +:
                                                           CHANNEL_WIDTH_IN]),
                                                 64'(grant_idx), TAG_LSB, TAG_MSB));

  // One-hot ready to the granted channel plus next pointer and occupancy.
  always_comb begin
    in_ready = '0;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      in_ready[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == PtrW'(NUM_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
    count_d = count_q;
    if (accept && !pop) count_d = count_q + 2'd1;
    else if (!accept && pop) count_d = count_q - 2'd1;
  end

  // Pointer and skid buffer state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      count_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (accept) begin
        skid_q[wr_ptr_q] <= msg;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef BORDER_PACKER_STATS_EN
  logic [StatsWidth-1:0] acc_q [NUM_CHANNELS];
  logic [StatsWidth-1:0] stall_q;

  // Saturating per-channel accept counters and output stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) acc_q[c] <= '0;
      stall_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (accept && grant_idx == PtrW'(c) && acc_q[c] != '1) acc_q[c] <= acc_q[c] + 1'b1;
      end
      if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  // Flatten counters: channel fields first, stall counter on top.
  always_comb begin
    stats = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) stats[c*16 +: 16] = acc_q[c];
    stats[NUM_CHANNELS*16 +: 16] = stall_q;
  end
`else
  assign stats = '0;
`endif

endmodule

// File: tb/tb_border_rr_packer.sv
// Self-checking bench for border_rr_packer: directed phases plus randomized
// traffic against a queue-based reference model.
module tb_border_rr_packer;

  localparam int NCH = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [159:0] in_data;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [95:0]  stats;

  border_rr_packer dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .stats    (stats)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] src [NCH][$];
  logic [63:0] mq[$];
  int          m_ptr;
  int          acc_cnt[NCH];
  int          stall_cnt;
  int          n_acc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream holds the head of each channel queue until it is accepted.
  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      in_valid[c] = (src[c].size() > 0);
      in_data[c*32 +: 32] = (src[c].size() > 0) ? src[c][0] : $urandom;
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic check_cycle();
    int          g;
    bit          gv;
    logic [4:0]  exp_rdy;
    logic [95:0] exp_stats;
    bit          ov;
    gv = 0;
    g  = 0;
    for (int i = 0; i < NCH; i++) begin
      int c = (m_ptr + i) % NCH;
      if (!gv && src[c].size() > 0) begin
        gv = 1;
        g  = c;
      end
    end
    exp_rdy = (gv && mq.size() < 2) ? (5'b1 << g) : 5'b0;
    ov = (mq.size() > 0);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, ov);
    if (ov) check_eq("out_data", out_data, mq[0]);
    check_eq("busy", busy, (|in_valid) | ov);
    exp_stats = '0;
`ifdef BORDER_PACKER_STATS_EN
    for (int c = 0; c < NCH; c++) exp_stats[c*16 +: 16] = 16'(acc_cnt[c]);
    exp_stats[80 +: 16] = 16'(stall_cnt);
`endif
    check_eq("stats", stats, exp_stats);
    if (ov && !out_ready && stall_cnt < 65535) stall_cnt++;
    if (ov && out_ready) void'(mq.pop_front());
    if (exp_rdy != 0) begin
      mq.push_back((64'(g) << 48) | 64'(src[g][0]));
      void'(src[g].pop_front());
      m_ptr = (g + 1) % NCH;
      if (acc_cnt[g] < 65535) acc_cnt[g]++;
      n_acc++;
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_idle();
    bit idle = (mq.size() == 0);
    for (int c = 0; c < NCH; c++) if (src[c].size() > 0) idle = 0;
    return idle;
  endfunction

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !model_idle(); i++) step();
    check_eq("drained", model_idle(), 1'b1);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ptr     = 0;
    stall_cnt = 0;
    for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
  endtask

  initial begin
    int base;
    model_reset();
    n_acc     = 0;
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    #12;
    // Reset state, including busy tracking in_valid while held in reset.
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 5'b0);
    check_eq("rst_out_data", out_data, 64'h0);
    check_eq("rst_stats", stats, 96'h0);
    check_eq("rst_busy_idle", busy, 1'b0);
    in_valid = 5'b00100;
    #1;
    check_eq("rst_busy_valid", busy, 1'b1);
    check_eq("rst_in_ready_v", in_ready, 5'b0);
    in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single channel with fixed payload.
    out_ready = 1'b1;
    src[2].push_back(32'hDEADBEEF);
    step();
    drive();
    @(negedge clk);
    check_eq("single_pkt", out_data, 64'h0002_0000_DEADBEEF);
    check_eq("single_valid", out_valid, 1'b1);
    check_cycle();
    @(posedge clk);
    #1;
    drain();

    // Fairness: all channels busy.
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 10; k++) src[c].push_back($urandom);
    base = n_acc;
    for (int i = 0; i < 50; i++) step();
    check_eq("fair_rate", n_acc - base, 50);
    drain();

    // Wrap skip: park pointer at 4, then alternate 4 and 0.
    src[3].push_back($urandom);
    step();
    check_eq("ptr_at_4", m_ptr, 4);
    drain();
    for (int k = 0; k < 4; k++) begin
      src[0].push_back($urandom);
      src[4].push_back($urandom);
    end
    drain();

    // Backpressure with channels 1 and 3.
    for (int k = 0; k < 4; k++) begin
      src[1].push_back($urandom);
      src[3].push_back($urandom);
    end
    out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 10; i++) step();
    check_eq("bp_accepts", n_acc - base, 2);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0 && src[c].size() < 4) src[c].push_back($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset with a full buffer.
    for (int c = 0; c < NCH; c++) src[c].push_back($urandom);
    out_ready = 1'b0;
    for (int i = 0; i < 10 && mq.size() < 2; i++) step();
    check_eq("full_before_rst", mq.size(), 2);
    drive();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_in_ready", in_ready, 5'b0);
    check_eq("midrst_stats", stats, 96'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("post_rst_grant", in_ready, in_valid & (~in_valid + 5'd1));
    check_cycle();
    @(posedge clk);
    #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
